// File: rtl/regf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package regf_pkg;

  localparam int NREG   = 32;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xword_t;

endpackage

// File: rtl/regf_scoreboard.sv
// Busy scoreboard of outstanding MDU destinations and the decode hazard lookup.
module regf_scoreboard
  import regf_pkg::*;
#(
  parameter int NREG = regf_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [4:0]        set_rd,
  input  logic              clr_en,
  input  logic [4:0]        clr_rd,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic [4:0]        dec_rd,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              dec_rd_en,
  output logic              hazard,
  output logic [NREG-1:0]   busy
);

  localparam logic [NREG-1:0] X0_MASK = {{(NREG-1){1'b1}}, 1'b0};

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] pending;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_rd != '0) set_vec[set_rd] = 1'b1;
    if (clr_en) clr_vec[clr_rd] = 1'b1;
  end

  // Set is ORed in after the clear so a same-index collision stays busy.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= ((busy_q & ~clr_vec) | set_vec) & X0_MASK;
  end

  // A register being written back this cycle is forwarded by the register
  // file, so it no longer blocks decode.
  assign pending = busy_q & ~clr_vec;

  assign hazard = (dec_use_rs1 & pending[dec_rs1])
                | (dec_use_rs2 & pending[dec_rs2])
                | (dec_rd_en   & pending[dec_rd]);

  assign busy = busy_q;

endmodule

// File: rtl/regf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. MDU results,
// with anti-starvation stall and an MDU destination scoreboard.
module regf_wb_arbiter
  import regf_pkg::*;
#(
  parameter int NREG       = regf_pkg::NREG,
  parameter int XLEN       = regf_pkg::XLEN,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pipe_wb_en,
  input  logic [4:0]       pipe_wb_rd,
  input  logic [XLEN-1:0]  pipe_wb_data,
  output logic             pipe_wb_stall,
  input  logic             mdu_issue_valid,
  input  logic [4:0]       mdu_issue_rd,
  input  logic             mdu_res_valid,
  input  logic [4:0]       mdu_res_rd,
  input  logic [XLEN-1:0]  mdu_res_data,
  output logic             mdu_res_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_use_rs1,
  input  logic             dec_use_rs2,
  input  logic             dec_rd_en,
  output logic             dec_hazard,
  output logic             regf_we,
  output logic [4:0]       regf_rd,
  output logic [XLEN-1:0]  regf_data,
  output logic [NREG-1:0]  busy_mask
);

  localparam logic [3:0] STARVE_LAST = 4'(STARVE_MAX - 1);

  logic            stall_q;
  logic [3:0]      starve_cnt;
  logic            stall_eff;
  logic            pipe_gnt;
  logic            mdu_gnt;
  logic            mdu_blocked;
  logic            hazard_raw;
  logic [NREG-1:0] busy_raw;

  // MDU result channel is valid/ready: a result transfers in any cycle where
  // mdu_res_valid & mdu_res_ready, and the MDU holds it stable until then.
  assign stall_eff   = stall_q & mdu_res_valid;
  assign pipe_gnt    = ~rst & pipe_wb_en & ~stall_eff;
  assign mdu_gnt     = ~rst & mdu_res_valid & ~pipe_gnt;
  assign mdu_blocked = mdu_res_valid & ~mdu_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      starve_cnt <= mdu_blocked ? starve_cnt + 4'd1 : 4'd0;
      stall_q    <= mdu_blocked && (starve_cnt == STARVE_LAST);
    end
  end

  always_comb begin
    regf_rd   = '0;
    regf_data = '0;
    if (pipe_gnt) begin
      regf_rd   = pipe_wb_rd;
      regf_data = pipe_wb_data;
    end else if (mdu_gnt) begin
      regf_rd   = mdu_res_rd;
      regf_data = mdu_res_data;
    end
    regf_we = (pipe_gnt | mdu_gnt) & (regf_rd != '0);
  end

  regf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en      (mdu_issue_valid),
    .set_rd      (mdu_issue_rd),
    .clr_en      (mdu_gnt),
    .clr_rd      (mdu_res_rd),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_rd      (dec_rd),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .dec_rd_en   (dec_rd_en),
    .hazard      (hazard_raw),
    .busy        (busy_raw)
  );

  assign mdu_res_ready = mdu_gnt;
  assign pipe_wb_stall = ~rst & stall_eff;
  assign dec_hazard    = ~rst & hazard_raw;
  assign busy_mask     = rst ? '0 : busy_raw;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Table-driven bench for regf_wb_arbiter with a write-port scoreboard queue.
module tb_regf_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        pipe_wb_en;
  logic [4:0]  pipe_wb_rd;
  logic [31:0] pipe_wb_data;
  logic        pipe_wb_stall;
  logic        mdu_issue_valid;
  logic [4:0]  mdu_issue_rd;
  logic        mdu_res_valid;
  logic [4:0]  mdu_res_rd;
  logic [31:0] mdu_res_data;
  logic        mdu_res_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_rd_en;
  logic        dec_hazard;
  logic        regf_we;
  logic [4:0]  regf_rd;
  logic [31:0] regf_data;
  logic [31:0] busy_mask;

  regf_wb_arbiter #(.NREG(32), .XLEN(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_rd(pipe_wb_rd), .pipe_wb_data(pipe_wb_data),
    .pipe_wb_stall(pipe_wb_stall),
    .mdu_issue_valid(mdu_issue_valid), .mdu_issue_rd(mdu_issue_rd),
    .mdu_res_valid(mdu_res_valid), .mdu_res_rd(mdu_res_rd), .mdu_res_data(mdu_res_data),
    .mdu_res_ready(mdu_res_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_rd_en(dec_rd_en),
    .dec_hazard(dec_hazard),
    .regf_we(regf_we), .regf_rd(regf_rd), .regf_data(regf_data),
    .busy_mask(busy_mask)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        r;
    logic        pe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        rv;
    logic [4:0]  rrd;
    logic [31:0] rdata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1, rs2, drd;
    logic        u1, u2, de;
    logic        e_ready;
    logic        e_stall;
    logic        e_haz;
    logic [31:0] e_busy;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  logic [36:0] exp_q[$];
  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string name, input int id, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %h expected %h", name, id, act, exp);
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.r;
    pipe_wb_en = v.pe; pipe_wb_rd = v.prd; pipe_wb_data = v.pdata;
    mdu_res_valid = v.rv; mdu_res_rd = v.rrd; mdu_res_data = v.rdata;
    mdu_issue_valid = v.iv; mdu_issue_rd = v.ird;
    dec_rs1 = v.rs1; dec_rs2 = v.rs2; dec_rd = v.drd;
    dec_use_rs1 = v.u1; dec_use_rs2 = v.u2; dec_rd_en = v.de;
    if (v.e_we) exp_q.push_back({v.e_rd, v.e_data});
  endtask

  // Called at a negedge: drive, sample mid-low-phase, advance to next negedge.
  task automatic run_vec(input vec_t v, input int id);
    logic [36:0] got;
    drive(v);
    #4;
    check("mdu_res_ready", id, 64'(mdu_res_ready), 64'(v.e_ready));
    check("pipe_wb_stall", id, 64'(pipe_wb_stall), 64'(v.e_stall));
    check("dec_hazard",    id, 64'(dec_hazard),    64'(v.e_haz));
    check("busy_mask",     id, 64'(busy_mask),     64'(v.e_busy));
    check("regf_we",       id, 64'(regf_we),       64'(v.e_we));
    if (regf_we) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", id, 64'({regf_rd, regf_data}), 64'(0));
      end else begin
        got = exp_q.pop_front();
        check("wb_rd_data", id, 64'({regf_rd, regf_data}), 64'(got));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    v = idle(); v.r = 1'b1;
    drive(v);
    @(negedge clk);

    // Reset with an MDU result presented: nothing accepted.
    for (int i = 0; i < 2; i++) begin
      v = idle(); v.r = 1; v.rv = 1; v.rrd = 5'd7; v.rdata = 32'h1;
      run_vec(v, 100 + i);
    end

    // Contention: issue rd7, then pipe rd5 vs MDU rd7, then MDU alone.
    v = idle(); v.iv = 1; v.ird = 7; tbl.push_back(v);
    v = idle(); v.pe = 1; v.prd = 5; v.pdata = 32'hA5A5A5A5; v.rv = 1; v.rrd = 7;
    v.rdata = 32'h12345678; v.e_busy = 32'h80; v.e_we = 1; v.e_rd = 5;
    v.e_data = 32'hA5A5A5A5; tbl.push_back(v);
    v = idle(); v.rv = 1; v.rrd = 7; v.rdata = 32'h12345678; v.e_busy = 32'h80;
    v.e_ready = 1; v.e_we = 1; v.e_rd = 7; v.e_data = 32'h12345678; tbl.push_back(v);
    v = idle(); tbl.push_back(v);
    // RAW on rd9 with the bypass in the grant cycle.
    v = idle(); v.iv = 1; v.ird = 9; tbl.push_back(v);
    v = idle(); v.u1 = 1; v.rs1 = 9; v.e_haz = 1; v.e_busy = 32'h200; tbl.push_back(v);
    v = idle(); v.u1 = 1; v.rs1 = 9; v.pe = 1; v.prd = 4; v.pdata = 32'h11; v.rv = 1;
    v.rrd = 9; v.rdata = 32'hDEAD; v.e_haz = 1; v.e_busy = 32'h200; v.e_we = 1;
    v.e_rd = 4; v.e_data = 32'h11; tbl.push_back(v);
    v = idle(); v.u1 = 1; v.rs1 = 9; v.rv = 1; v.rrd = 9; v.rdata = 32'hDEAD;
    v.e_busy = 32'h200; v.e_ready = 1; v.e_we = 1; v.e_rd = 9; v.e_data = 32'hDEAD;
    tbl.push_back(v);
    v = idle(); v.u1 = 1; v.rs1 = 9; tbl.push_back(v);
    // Set/clear collision on rd3.
    v = idle(); v.iv = 1; v.ird = 3; tbl.push_back(v);
    v = idle(); v.iv = 1; v.ird = 3; v.rv = 1; v.rrd = 3; v.rdata = 32'h33; v.u2 = 1;
    v.rs2 = 3; v.e_busy = 32'h8; v.e_ready = 1; v.e_we = 1; v.e_rd = 3;
    v.e_data = 32'h33; tbl.push_back(v);
    v = idle(); v.u2 = 1; v.rs2 = 3; v.e_haz = 1; v.e_busy = 32'h8; tbl.push_back(v);
    v = idle(); v.de = 1; v.drd = 3; v.rv = 1; v.rrd = 3; v.rdata = 32'h44;
    v.e_busy = 32'h8; v.e_ready = 1; v.e_we = 1; v.e_rd = 3; v.e_data = 32'h44;
    tbl.push_back(v);
    v = idle(); tbl.push_back(v);
    // x0 handling.
    v = idle(); v.iv = 1; v.ird = 0; v.u1 = 1; v.rs1 = 0; v.de = 1; v.drd = 0;
    tbl.push_back(v);
    v = idle(); v.rv = 1; v.rrd = 0; v.rdata = 32'h55; v.e_ready = 1; tbl.push_back(v);
    v = idle(); v.u2 = 1; v.rs2 = 0; tbl.push_back(v);
    // WAW on rd20, plus an illegal pipeline write to the busy rd.
    v = idle(); v.iv = 1; v.ird = 20; tbl.push_back(v);
    v = idle(); v.de = 1; v.drd = 20; v.e_haz = 1; v.e_busy = 32'h100000; tbl.push_back(v);
    v = idle(); v.pe = 1; v.prd = 20; v.pdata = 32'h77; v.e_busy = 32'h100000;
    v.e_we = 1; v.e_rd = 20; v.e_data = 32'h77; tbl.push_back(v);
    v = idle(); v.rv = 1; v.rrd = 20; v.rdata = 32'h88; v.e_busy = 32'h100000;
    v.e_ready = 1; v.e_we = 1; v.e_rd = 20; v.e_data = 32'h88; tbl.push_back(v);
    v = idle(); tbl.push_back(v);
    v = idle(); v.pe = 1; v.prd = 0; v.pdata = 32'h99; tbl.push_back(v);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Starvation: two results queued, pipeline writes every cycle.
    v = idle(); v.iv = 1; v.ird = 10; run_vec(v, 200);
    v = idle(); v.iv = 1; v.ird = 11; v.e_busy = 32'h400; run_vec(v, 201);
    for (int c = 1; c <= 10; c++) begin
      logic [4:0] mrd;
      mrd = (c <= 5) ? 5'd10 : 5'd11;
      v = idle();
      v.pe = 1; v.prd = 6; v.pdata = 32'h100 + 32'(c);
      v.rv = 1; v.rrd = mrd; v.rdata = 32'hCAFE0000 + 32'(mrd);
      v.e_busy = (c <= 5) ? 32'hC00 : 32'h800;
      v.e_stall = (c == 5 || c == 10);
      v.e_ready = v.e_stall;
      v.e_we = 1;
      v.e_rd = v.e_stall ? mrd : 5'd6;
      v.e_data = v.e_stall ? v.rdata : v.pdata;
      run_vec(v, 210 + c);
    end
    v = idle(); run_vec(v, 230);

    // Reset mid-operation drops pending scoreboard state.
    v = idle(); v.iv = 1; v.ird = 12; run_vec(v, 240);
    v = idle(); v.r = 1; v.rv = 1; v.rrd = 12; v.pe = 1; v.prd = 1; v.u1 = 1; v.rs1 = 12;
    run_vec(v, 241);
    v = idle(); v.u1 = 1; v.rs1 = 12; run_vec(v, 242);

    check("exp_q_empty", 999, 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
